sha256_main_ctrl: RTL and testbench
===================================

Name: sha256_main_ctrl

Overview:
Round sequencer for the SHA-256 message-schedule and compression datapath. Accepts one 512-bit block as 16 streamed 32-bit words over a valid/ready handshake and drives the schedule unit's w_vld/w_data/w_cnt. Steps rounds 0..63, issues hash-state init/update strobes and signals digest completion. Sits between the host-side word interface and the calw/compression datapath.

Parameters:
P_WIDTH, 32, data word width; only 32 supported.
P_LOAD_WORDS, 16, message words loaded per block; fixed at 16.
P_ROUNDS, 64, rounds per block; fixed at 64; w_cnt width 6.

Ports:
clk  in  1  clock; all state on rising edge
reset_n  in  1  asynchronous active-low reset
init  in  1  start first block of a new message (sampled in IDLE only)
next  in  1  start a continuation block (sampled in IDLE only)
msg_vld  in  1  message word valid
msg_data  in  32  message word, big-endian word order W0 first
msg_rdy  out  1  controller accepts msg_data this cycle
w_vld  out  1  schedule/round advance strobe
w_data  out  32  word to schedule unit
w_cnt  out  6  current round index 0..63
k_addr  out  6  round-constant ROM address (= w_cnt)
h_init  out  1  one-cycle pulse: load IV into hash state
h_upd  out  1  one-cycle pulse: add working vars into hash state
digest_vld  out  1  one-cycle pulse: digest valid
busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0): state=IDLE, w_cnt=0, h_init=h_upd=digest_vld=0, busy=0, msg_rdy=0, w_vld=0. Reset mid-block abandons the block; no h_upd is issued.
- States: IDLE, LOAD, EXPAND, FINAL.
- IDLE: init=1 -> LOAD with h_init=1 for that cycle (registered, visible the first LOAD cycle). init=0, next=1 -> LOAD with no h_init. init and next both high: init wins. Otherwise stay.
- LOAD: msg_rdy=1 (combinational from state). Transfer = msg_vld & msg_rdy. w_vld = transfer; w_data = msg_data passthrough. Each transfer increments w_cnt. Transfer at w_cnt=15 -> EXPAND. msg_vld=0 stalls: w_vld=0, w_cnt holds, no timeout.
- EXPAND: msg_rdy=0, w_vld=1 every cycle, w_data=msg_data (ignored downstream since w_cnt[5:4]!=0), w_cnt increments. At w_cnt=63 with w_vld -> FINAL, w_cnt wraps to 0.
- FINAL: one cycle, h_upd=1, -> IDLE. digest_vld=1 the following cycle (first IDLE cycle), registered.
- init/next ignored outside IDLE; a start request in the digest_vld cycle is accepted (back-to-back blocks).
- Unstalled latency: first transfer to h_upd = 64 cycles, digest_vld 1 cycle later.
- k_addr=w_cnt combinational. busy combinational from state.

Optional Feature:
SHA256_CTRL_HOLD_EN: adds input port hold (1 bit). When hold=1 in LOAD or EXPAND: msg_rdy=0, w_vld=0, w_cnt and state frozen; FINAL entry deferred until hold=0. IDLE/FINAL unaffected. Without the macro the port is absent and the block behaves as if hold=0.

Decomposition:
- Shared package sha256_pkg: state enum (IDLE, LOAD, EXPAND, FINAL), constants P_LOAD_WORDS=16, P_ROUNDS=64, LAST_LOAD=6'd15, LAST_ROUND=6'd63.
- State register uses existing sha256_regx-style flops with async reset. No further sub-module; counter and FSM in one module.

Test Plan:
- Reset, init=1 one cycle, stream "abc" block (0x61626380, 14x0x00000000, 0x00000018) with msg_vld=1 -> h_init pulse at cycle 1, w_vld high 64 consecutive cycles, w_cnt 0..63, h_upd at cycle 65, digest_vld at cycle 66; with datapath, digest = ba7816bf...f20015ad.
- Same block, msg_vld low 3 cycles after word 5 -> w_vld=0 and w_cnt=5 during gap, msg_rdy stays 1, h_upd delayed to cycle 68.
- init=1 and next=1 together in IDLE -> h_init pulses once; next alone on second block -> no h_init, h_upd/digest_vld still pulse.
- reset_n low at w_cnt=40 in EXPAND -> all outputs 0 immediately, no h_upd; new init then runs full 64 rounds normally.
- next asserted in digest_vld cycle -> LOAD entered next cycle, msg_rdy=1, no idle gap; init pulses during EXPAND ignored.
- With SHA256_CTRL_HOLD_EN, hold=1 for 2 cycles at w_cnt=20 -> w_vld=0, w_cnt holds 20; h_upd shifted 2 cycles later.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared state encoding and round/load constants for the SHA-256 controller
package sha256_pkg;
  localparam int P_WIDTH = 32;
  localparam int P_LOAD_WORDS = 16;
  localparam int P_ROUNDS = 64;
  localparam logic [5:0] LAST_LOAD = 6'(P_LOAD_WORDS - 1);
  localparam logic [5:0] LAST_ROUND = 6'(P_ROUNDS - 1);
  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, FINAL} state_t;
endpackage

// File: rtl/sha256_main_ctrl.sv
// sha256_main_ctrl: SHA-256 round sequencer: 16-word block load, 64 rounds, hash init/update/digest strobes.
// Optional SHA256_CTRL_HOLD_EN adds a hold input that freezes LOAD/EXPAND progress.
module sha256_main_ctrl
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               init,
  input  logic               next,
`ifdef SHA256_CTRL_HOLD_EN
  input  logic               hold,
`endif
  input  logic               msg_vld,
  input  logic [P_WIDTH-1:0] msg_data,
  output logic               msg_rdy,
  output logic               w_vld,
  output logic [P_WIDTH-1:0] w_data,
  output logic [5:0]         w_cnt,
  output logic [5:0]         k_addr,
  output logic               h_init,
  output logic               h_upd,
  output logic               digest_vld,
  output logic               busy
);
  state_t state;
  logic hold_i;
`ifdef SHA256_CTRL_HOLD_EN
  assign hold_i = hold;
`else
  assign hold_i = 1'b0;
`endif
  assign msg_rdy = (state == LOAD) & ~hold_i;
  assign w_vld = ((state == LOAD) & msg_vld | (state == EXPAND)) & ~hold_i;
  assign w_data = msg_data;
  assign k_addr = w_cnt;
  assign busy = state != IDLE;
  // w_cnt wraps 63 -> 0 on its own, so every block starts at round 0
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      w_cnt <= '0;
      h_init <= 1'b0;
      h_upd <= 1'b0;
      digest_vld <= 1'b0;
    end else begin
      h_init <= (state == IDLE) & init;
      h_upd <= (state == EXPAND) & w_vld & (w_cnt == LAST_ROUND);
      digest_vld <= state == FINAL;
      w_cnt <= w_vld ? w_cnt + 6'd1 : w_cnt;
      unique case (state)
        IDLE:    state <= (init | next) ? LOAD : IDLE;
        LOAD:    state <= (w_vld && w_cnt == LAST_LOAD) ? EXPAND : LOAD;
        EXPAND:  state <= (w_vld && w_cnt == LAST_ROUND) ? FINAL : EXPAND;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sha256_main_ctrl.sv
// tb_sha256_main_ctrl: table-driven and randomized checks of the SHA-256 round sequencer timeline.
module tb_sha256_main_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, init = 1'b0, next = 1'b0, msg_vld = 1'b0;
  logic [31:0] msg_data = '0, w_data;
  logic msg_rdy, w_vld, h_init, h_upd, digest_vld, busy;
  logic [5:0] w_cnt, k_addr;
`ifdef SHA256_CTRL_HOLD_EN
  logic hold = 1'b0;
`endif
  int tests = 0, fails = 0;
  logic [31:0] blk [16];

  typedef struct {
    string name;
    bit ini;
    bit nxt;
    bit chain_in;
    int gap_after;
    int gap_len;
    bit rnd;
    bit exp_hinit;
    int exp_hupd;
  } vec_t;
  vec_t vecs [10];

  sha256_main_ctrl dut (
    .clk(clk), .reset_n(reset_n), .init(init), .next(next),
`ifdef SHA256_CTRL_HOLD_EN
    .hold(hold),
`endif
    .msg_vld(msg_vld), .msg_data(msg_data), .msg_rdy(msg_rdy), .w_vld(w_vld),
    .w_data(w_data), .w_cnt(w_cnt), .k_addr(k_addr), .h_init(h_init), .h_upd(h_upd),
    .digest_vld(digest_vld), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_msg_rdy"}, msg_rdy, 0);
    chk({tag, "_w_vld"}, w_vld, 0);
    chk({tag, "_w_cnt"}, w_cnt, 0);
    chk({tag, "_h_init"}, h_init, 0);
    chk({tag, "_h_upd"}, h_upd, 0);
    chk({tag, "_digest"}, digest_vld, 0);
  endtask

  // Model: the i-th accepted word carries round i; after the 16th word, 48
  // uninterrupted rounds follow, then one h_upd cycle, then one digest cycle.
  task automatic run_block(input vec_t v, input bit chain_out);
    int n = 0, e = 0, t = 1, gap = 0, t16 = -1, hupd_t = -1;
    bit done = 0;
    if (!v.chain_in) begin
      init = v.ini; next = v.nxt; msg_vld = 1'b0;
      #1 chk({v.name, "_start_busy"}, busy, 0);
      @(negedge clk);
    end
    while (!done && t < 400) begin
      init = v.rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      next = v.rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      msg_data = $urandom;
      if (n < 16) begin
        if (!v.rnd) msg_data = blk[n];
        msg_vld = v.rnd ? ($urandom_range(0, 3) != 0) : !(n == v.gap_after && gap < v.gap_len);
      end else msg_vld = 1'($urandom_range(0, 1));
      #1;
      chk({v.name, "_h_init"}, h_init, (t == 1) ? 32'(v.exp_hinit) : 0);
      chk({v.name, "_busy"}, busy, 1);
      chk({v.name, "_digest_low"}, digest_vld, 0);
      if (n < 16) begin
        chk({v.name, "_load_rdy"}, msg_rdy, 1);
        chk({v.name, "_load_wvld"}, w_vld, 32'(msg_vld));
        chk({v.name, "_load_cnt"}, w_cnt, n);
        chk({v.name, "_load_kaddr"}, k_addr, n);
        chk({v.name, "_load_hupd"}, h_upd, 0);
        if (msg_vld) chk({v.name, "_load_wdata"}, w_data, msg_data);
        if (msg_vld) begin
          n++;
          if (n == 16) t16 = t;
        end else gap++;
      end else if (e < 48) begin
        chk({v.name, "_exp_rdy"}, msg_rdy, 0);
        chk({v.name, "_exp_wvld"}, w_vld, 1);
        chk({v.name, "_exp_cnt"}, w_cnt, 16 + e);
        chk({v.name, "_exp_wdata"}, w_data, msg_data);
        chk({v.name, "_exp_hupd"}, h_upd, 0);
        e++;
      end else begin
        chk({v.name, "_fin_hupd"}, h_upd, 1);
        chk({v.name, "_fin_wvld"}, w_vld, 0);
        chk({v.name, "_fin_rdy"}, msg_rdy, 0);
        hupd_t = t;
        done = 1;
      end
      @(negedge clk);
      t++;
    end
    if (!done) chk({v.name, "_timeout"}, 1, 0);
    init = 1'b0; next = chain_out; msg_vld = 1'b0;
    #1;
    chk({v.name, "_digest"}, digest_vld, 1);
    chk({v.name, "_dig_hupd"}, h_upd, 0);
    chk({v.name, "_dig_busy"}, busy, 0);
    chk({v.name, "_dig_cnt"}, w_cnt, 0);
    chk({v.name, "_lat_model"}, hupd_t, t16 + 49);
    if (v.exp_hupd >= 0) chk({v.name, "_lat_table"}, hupd_t, v.exp_hupd);
    @(negedge clk);
    next = 1'b0;
    #1 chk({v.name, "_digest_pulse"}, digest_vld, 0);
    if (chain_out) chk({v.name, "_b2b_rdy"}, msg_rdy, 1);
  endtask

  initial begin
    int bad;
    vec_t abc;
    blk[0] = 32'h61626380;
    for (int i = 1; i < 15; i++) blk[i] = '0;
    blk[15] = 32'h00000018;
    vecs[0] = '{"abc_init", 1, 0, 0, -1, 0, 0, 1, 65};
    vecs[1] = '{"b2b_next", 0, 1, 1, -1, 0, 0, 0, 65};
    vecs[2] = '{"gap5x3", 1, 0, 0, 5, 3, 0, 1, 68};
    vecs[3] = '{"init_next", 1, 1, 0, -1, 0, 0, 1, 65};
    vecs[4] = '{"next_only", 0, 1, 0, -1, 0, 0, 0, 65};
    vecs[5] = '{"rnd_a", 1, 0, 0, -1, 0, 1, 1, -1};
    vecs[6] = '{"rnd_b", 0, 1, 0, -1, 0, 1, 0, -1};
    vecs[7] = '{"rnd_c", 1, 1, 0, -1, 0, 1, 1, -1};
    vecs[8] = '{"rnd_d", 0, 1, 0, -1, 0, 1, 0, -1};
    vecs[9] = '{"rnd_e", 1, 0, 0, -1, 0, 1, 1, -1};
    #3 chk_idle_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1 chk_idle_outputs("post_reset");
    for (int i = 0; i < 10; i++) run_block(vecs[i], (i < 9) ? vecs[i+1].chain_in : 1'b0);
    // abandon a block at round 40 with an asynchronous reset
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0; msg_vld = 1'b1;
    for (int i = 0; i < 100 && w_cnt != 6'd40; i++) begin
      msg_data = $urandom;
      @(negedge clk);
    end
    chk("mid_pre_cnt", w_cnt, 40);
    #2 reset_n = 1'b0;
    #1 chk_idle_outputs("mid_reset");
    @(negedge clk);
    reset_n = 1'b1; msg_vld = 1'b0;
    bad = 0;
    repeat (70) begin
      @(negedge clk);
      #1 if (h_upd || busy || digest_vld || w_vld) bad++;
    end
    chk("mid_no_hupd", bad, 0);
    abc = vecs[0];
    abc.name = "abc_after_rst";
    run_block(abc, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
